nrz_frame_deser: RTL and testbench

Mid-bit sampler, deserializer and frame synchroniser for the NRZ link. It sits directly downstream of the NRZ clock-recovery stage, which produces the recovered bit clock `cdr` as a level in the `clk` domain.

- It samples `nrz` at each falling edge of `cdr`, which is mid-bit.
- It hunts for a sync word and deframes fixed-length frames into W-bit words.
- Words are delivered on a valid/ready interface, with a lock flag and a flywheel on sync misses.

---
 rtl/nrz_pkg.sv | 17 +
 rtl/nrz_bit_sampler.sv | 38 +++
 rtl/nrz_frame_deser.sv | 150 +++++++++++++++
 tb/tb_nrz_frame_deser.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nrz_pkg.sv
// Shared types and sizing helpers for the NRZ frame deserializer.
package nrz_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2
    } frm_state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA7;

    // Counter width for a count range of 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nrz_bit_sampler.sv
// Aligns nrz with the recovered clock, detects cdr falling edges (mid-bit)
// and shifts the sampled bit into a W-bit register.
module nrz_bit_sampler #(
    parameter int W         = 8,
    parameter int ALIGN_DLY = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         nrz,
    input  logic         cdr,
    output logic         fall,
    output logic [W-1:0] sh_nx,
    output logic [W-1:0] sh
);

    logic [ALIGN_DLY-1:0] dly;
    logic                 cdr_d;
    logic                 nrz_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly   <= '0;
            cdr_d <= 1'b0;
            sh    <= '0;
        end else begin
            dly[0] <= nrz;
            for (int i = 1; i < ALIGN_DLY; i++) dly[i] <= dly[i-1];
            cdr_d <= cdr;
            if (fall) sh <= sh_nx;
        end
    end

    // nrz is delayed to match the latency the CDR stage adds to cdr.
    assign nrz_a = dly[ALIGN_DLY-1];
    assign fall  = cdr_d & ~cdr;
    assign sh_nx = {sh[W-2:0], nrz_a};

endmodule

// File: rtl/nrz_frame_deser.sv
// NRZ deserializer and frame synchroniser: hunts for SYNC, deframes
// FRAME_WORDS words per frame and flywheels over isolated sync misses.
module nrz_frame_deser import nrz_pkg::*; #(
    parameter int           W           = 8,
    parameter logic [W-1:0] SYNC        = W'(SYNC_DEFAULT),
    parameter int           FRAME_WORDS = 16,
    parameter int           MISS_MAX    = 3,
    parameter int           ALIGN_DLY   = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         nrz,
    input  logic         cdr,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_sof,
    output logic         locked,
    output logic         sync_miss,
    output logic         overflow,
    input  logic         ovf_clr
);

    localparam int BW  = cnt_w(W);
    localparam int WCW = cnt_w(FRAME_WORDS);
    localparam int MW  = cnt_w(MISS_MAX);

    logic           fall;
    logic [W-1:0]   sh_nx;
    logic [W-1:0]   sh_unused;

    frm_state_t     state;
    logic [BW-1:0]  bitcnt;
    logic [WCW-1:0] wordcnt;
    logic [MW-1:0]  miss;
    logic           sof_pend;

    logic           match;
    logic           bit_last;
    logic           word_last;
    logic           miss_last;
    logic           emit;
    logic           enter_data;

    nrz_bit_sampler #(
        .W         (W),
        .ALIGN_DLY (ALIGN_DLY)
    ) u_sampler (
        .clk   (clk),
        .rst_n (rst_n),
        .nrz   (nrz),
        .cdr   (cdr),
        .fall  (fall),
        .sh_nx (sh_nx),
        .sh    (sh_unused)
    );

    assign match     = (sh_nx == SYNC);
    assign bit_last  = (bitcnt == BW'(W - 1));
    assign word_last = (wordcnt == WCW'(FRAME_WORDS - 1));
    assign miss_last = (miss == MW'(MISS_MAX - 1));

    assign emit       = fall && (state == DATA) && bit_last;
    assign enter_data = fall && (((state == HUNT) && match) ||
                                 ((state == CHECK) && bit_last && (match || !miss_last)));

    assign locked = (state != HUNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            bitcnt    <= '0;
            wordcnt   <= '0;
            miss      <= '0;
            sync_miss <= 1'b0;
        end else begin
            sync_miss <= 1'b0;
            if (fall) begin
                case (state)
                    HUNT: begin
                        if (match) begin
                            state   <= DATA;
                            bitcnt  <= '0;
                            wordcnt <= '0;
                            miss    <= '0;
                        end
                    end
                    DATA: begin
                        if (bit_last) begin
                            bitcnt <= '0;
                            if (word_last) state <= CHECK;
                            else           wordcnt <= wordcnt + 1'b1;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                    CHECK: begin
                        if (bit_last) begin
                            bitcnt  <= '0;
                            wordcnt <= '0;
                            if (match) begin
                                miss  <= '0;
                                state <= DATA;
                            end else begin
                                sync_miss <= 1'b1;
                                // Flywheel: keep the assumed frame position until too many misses.
                                if (miss_last) begin
                                    state <= HUNT;
                                end else begin
                                    miss  <= miss + 1'b1;
                                    state <= DATA;
                                end
                            end
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            overflow  <= 1'b0;
            sof_pend  <= 1'b0;
        end else begin
            if (enter_data) sof_pend <= 1'b1;
            if (ovf_clr)    overflow <= 1'b0;
            if (emit) begin
                sof_pend <= 1'b0;
                if (!out_valid || out_ready) begin
                    out_data  <= sh_nx;
                    out_sof   <= sof_pend;
                    out_valid <= 1'b1;
                end else begin
                    // Held word wins; the new one is lost and flagged.
                    overflow <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nrz_frame_deser.sv
// Randomized scoreboard bench for nrz_frame_deser against a bit-stream frame model.
module tb_nrz_frame_deser;

    localparam int         W   = 8;
    localparam int         FW  = 16;
    localparam int         MM  = 3;
    localparam int         PER = (FW + 1) * W;
    localparam logic [7:0] SYNC = 8'hA7;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         nrz = 1'b0;
    logic         cdr = 1'b0;
    logic         out_ready = 1'b0;
    logic         ovf_clr = 1'b0;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_sof;
    logic         locked;
    logic         sync_miss;
    logic         overflow;

    always #5 clk = ~clk;

    nrz_frame_deser #(
        .W(W), .SYNC(SYNC), .FRAME_WORDS(FW), .MISS_MAX(MM), .ALIGN_DLY(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .nrz(nrz), .cdr(cdr),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .locked(locked), .sync_miss(sync_miss),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   miss_seen = 0;
    int   miss_exp = 0;

    // Reference model: last W line bits, lock flag, bit position since the last sync.
    logic [7:0] win = '0;
    bit         m_locked = 0;
    int         pos = 0;
    int         misses = 0;
    bit         sof_next = 0;
    int         drop_n = 0;

    int rdy_mode = 1;
    bit fall_rdy = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        win = '0; m_locked = 0; pos = 0; misses = 0; sof_next = 0; drop_n = 0;
        q.delete();
    endtask

    task automatic model_bit(input logic b);
        exp_t e;
        win = {win[6:0], b};
        if (!m_locked) begin
            if (win == SYNC) begin
                m_locked = 1; pos = 0; misses = 0; sof_next = 1;
            end
        end else begin
            pos++;
            if (pos <= FW * W && pos % W == 0) begin
                if (drop_n > 0) drop_n--;
                else begin
                    e.d = win; e.sof = sof_next;
                    q.push_back(e);
                end
                sof_next = 0;
            end
            if (pos == PER) begin
                pos = 0;
                if (win == SYNC) misses = 0;
                else begin
                    miss_exp++;
                    misses++;
                end
                if (misses == MM) m_locked = 0;
                else sof_next = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    // One bit period of 16 clk: cdr high for the first half, falls mid-bit.
    task automatic send_bit(input logic b);
        model_bit(b);
        nrz = b;
        cdr = 1'b1;
        repeat (8) tick();
        cdr = 1'b0;
        if (fall_rdy) out_ready = 1'b1;
        repeat (8) tick();
        chk1("locked", locked, m_locked);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_rand(input int n);
        for (int i = 0; i < n; i++) send_byte(8'($urandom));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got %02h with nothing expected at %0t", out_data, $time);
            end else begin
                e = q.pop_front();
                chk8("word_data", out_data, e.d);
                chk1("word_sof", out_sof, e.sof);
            end
        end
        if (sync_miss) miss_seen++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] w0, w1, w2, w3;
        repeat (3) @(posedge clk);
        #1;
        chk8("rst_data", out_data, 8'h00);
        chk1("rst_valid", out_valid, 1'b0);
        chk1("rst_sof", out_sof, 1'b0);
        chk1("rst_locked", locked, 1'b0);
        chk1("rst_sync_miss", sync_miss, 1'b0);
        chk1("rst_overflow", overflow, 1'b0);
        rst_n = 1'b1;
        repeat (4) tick();

        // Basic frame
        send_byte(SYNC);
        for (int i = 0; i < FW; i++) send_byte(8'(i));

        // Single corrupted sync flywheels, then a good sync clears the miss count
        send_byte(8'hA6);
        send_rand(FW);
        send_byte(SYNC);
        send_rand(FW);

        // Three consecutive bad syncs drop lock
        for (int k = 0; k < 3; k++) begin
            send_byte(8'hA6);
            if (k < 2) send_rand(FW);
        end
        chk1("lock_lost", locked, 1'b0);
        for (int i = 0; i < FW; i++) send_byte(8'h00);

        // Misaligned hunt
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        send_byte(SYNC);
        for (int i = 0; i < FW; i++) send_byte(8'(i));

        // Backpressure: first word held, second dropped
        send_byte(SYNC);
        rdy_mode = 0;
        w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom); w3 = 8'($urandom);
        send_byte(w0);
        drop_n = 1;
        send_byte(w1);
        chk1("ovf_set", overflow, 1'b1);
        chk1("ovf_valid", out_valid, 1'b1);
        chk8("ovf_held_data", out_data, w0);
        chk1("ovf_held_sof", out_sof, 1'b1);
        rdy_mode = 1;
        repeat (3) tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        tick();
        chk1("ovf_cleared", overflow, 1'b0);

        // Handshake in the same cycle as an emit
        rdy_mode = 0;
        send_byte(w2);
        for (int i = 7; i >= 1; i--) send_bit(w3[i]);
        fall_rdy = 1;
        send_bit(w3[0]);
        fall_rdy = 0;
        chk1("hs_emit_valid", out_valid, 1'b1);
        chk8("hs_emit_data", out_data, w3);
        chk1("hs_emit_no_ovf", overflow, 1'b0);
        rdy_mode = 2;
        send_rand(FW - 4);

        // Stuck cdr mid-frame
        rdy_mode = 1;
        send_byte(SYNC);
        send_rand(5);
        cdr = 1'b1;
        repeat (1000) tick();
        chk1("stall_valid", out_valid, 1'b0);
        chk1("stall_locked", locked, m_locked);
        send_rand(FW - 5);

        // Async reset mid-word
        send_byte(SYNC);
        send_rand(2);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk8("arst_data", out_data, 8'h00);
        chk1("arst_valid", out_valid, 1'b0);
        chk1("arst_sof", out_sof, 1'b0);
        chk1("arst_locked", locked, 1'b0);
        chk1("arst_sync_miss", sync_miss, 1'b0);
        chk1("arst_overflow", overflow, 1'b0);
        model_reset();
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(1'($urandom));
        send_rand(FW - 3);
        rdy_mode = 2;
        send_byte(SYNC);
        send_rand(FW);
        send_byte(SYNC);
        send_rand(2);

        rdy_mode = 1;
        repeat (40) tick();
        chki("queue_drained", q.size(), 0);
        chki("sync_miss_count", miss_seen, miss_exp);
        chk1("final_overflow", overflow, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
